// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states and the
// rounded oversample tick divider used by both receiver and transmitter.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  function automatic int tick_div(input int clk_hz, input int baud, input int os);
    return (clk_hz + baud * os / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, first pulse DIV
// cycles after clear; no backpressure, clear restarts the phase immediately.
module uart_baud_tick #(
  parameter int DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with 3-sample majority vote; frame presented one cycle
// after the final stop-bit vote, held until valid&&ready, dropped with overrun if still pending.
module uart_rx_cfg import uart_pkg::*; #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 9600,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int OVERSAMPLE      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TICK_DIV = tick_div(CLOCK_FREQUENCY, BAUD_RATE, OVERSAMPLE);
  localparam int OS_W     = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] T_S0   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] T_S1   = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] T_S2   = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0] T_LAST = OS_W'(OVERSAMPLE - 1);

  rx_state_t state, state_nxt;

  logic                 rx_meta, rx_s, rx_prev;
  logic                 start_det, tick, vote_pt, vote;
  logic                 s0, s1;
  logic [OS_W-1:0]      t_cnt;
  logic [3:0]           bit_idx;
  logic                 last_data, last_stop, frame_done, exp_par;
  logic [DATA_BITS-1:0] shift;
  logic                 perr_acc, ferr_acc;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // A line held low (break) never re-arms until rx_s has been seen high again.
  assign start_det = (state == ST_IDLE) && rx_prev && !rx_s;

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (start_det),
    .tick  (tick)
  );

  assign vote_pt    = tick && (t_cnt == T_S2) && (state != ST_IDLE);
  assign vote       = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign last_data  = (bit_idx == 4'(DATA_BITS - 1));
  assign last_stop  = (bit_idx == 4'(STOP_BITS - 1));
  assign frame_done = (state == ST_STOP) && vote_pt && last_stop;
  assign exp_par    = (PARITY == PARITY_ODD) ? ~(^shift) : ^shift;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_det) state_nxt = ST_START;
      ST_START:  if (vote_pt) state_nxt = vote ? ST_IDLE : ST_DATA;
      ST_DATA:   if (vote_pt && last_data)
                   state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (vote_pt) state_nxt = ST_STOP;
      ST_STOP:   if (vote_pt && last_stop) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  // Bit decisions happen mid-bit; t_cnt keeps running so the next bit stays aligned.
  always_ff @(posedge clock) begin
    if (reset) begin
      t_cnt    <= '0;
      bit_idx  <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      shift    <= '0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (start_det) begin
      t_cnt    <= '0;
      bit_idx  <= '0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
    end else if (tick && state != ST_IDLE) begin
      t_cnt <= (t_cnt == T_LAST) ? '0 : t_cnt + OS_W'(1);
      if (t_cnt == T_S0) s0 <= rx_s;
      if (t_cnt == T_S1) s1 <= rx_s;
      if (t_cnt == T_S2) begin
        case (state)
          ST_DATA: begin
            shift   <= {vote, shift[DATA_BITS-1:1]};
            bit_idx <= last_data ? 4'd0 : bit_idx + 4'd1;
          end
          ST_PARITY: perr_acc <= (vote != exp_par);
          ST_STOP: begin
            ferr_acc <= ferr_acc | ~vote;
            bit_idx  <= bit_idx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data          <= '0;
      valid         <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_done) begin
        if (!valid || ready) begin
          data          <= shift;
          parity_error  <= perr_acc;
          framing_error <= ferr_acc | ~vote;
          valid         <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8N1 instance and an 8E1 instance, each fed
// from its own serial line, expected frames queued at send time and checked on accept.
module tb_uart_rx_cfg;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset, rx, rx_e, ready, ready_e;
  logic [7:0] data, data_e;
  logic       valid, parity_error, framing_error, overrun, busy;
  logic       valid_e, parity_error_e, framing_error_e, overrun_e, busy_e;

  int checks = 0;
  int failures = 0;
  int valid_cycles = 0;
  int ovr_cnt = 0;
  int ovr_e_cnt = 0;
  int busy_rise = 0;
  logic busy_d = 1'b0;
  exp_t q_main[$];
  exp_t q_e[$];
  exp_t m_exp, e_exp;

  always #5 clock = ~clock;

  uart_rx_cfg #(
    .CLOCK_FREQUENCY(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)
  ) dut (
    .clock(clock), .reset(reset), .rx(rx), .data(data), .valid(valid), .ready(ready),
    .parity_error(parity_error), .framing_error(framing_error), .overrun(overrun), .busy(busy)
  );

  uart_rx_cfg #(
    .CLOCK_FREQUENCY(1600000), .BAUD_RATE(100000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16)
  ) dut_e (
    .clock(clock), .reset(reset), .rx(rx_e), .data(data_e), .valid(valid_e), .ready(ready_e),
    .parity_error(parity_error_e), .framing_error(framing_error_e), .overrun(overrun_e),
    .busy(busy_e)
  );

  always @(negedge clock) begin
    if (!reset) begin
      if (valid) valid_cycles++;
      if (overrun) ovr_cnt++;
      if (overrun_e) ovr_e_cnt++;
      if (busy && !busy_d) busy_rise++;
      busy_d = busy;
      if (valid && ready) begin
        checks++;
        if (q_main.size() == 0) begin
          failures++;
          $display("FAIL main_unexpected_frame got data=%h pe=%b fe=%b", data, parity_error, framing_error);
        end else begin
          m_exp = q_main.pop_front();
          if ({data, parity_error, framing_error} !== m_exp) begin
            failures++;
            $display("FAIL main_frame got data=%h pe=%b fe=%b want data=%h pe=%b fe=%b",
                     data, parity_error, framing_error, m_exp.d, m_exp.pe, m_exp.fe);
          end
        end
      end
      if (valid_e && ready_e) begin
        checks++;
        if (q_e.size() == 0) begin
          failures++;
          $display("FAIL even_unexpected_frame got data=%h pe=%b fe=%b", data_e, parity_error_e, framing_error_e);
        end else begin
          e_exp = q_e.pop_front();
          if ({data_e, parity_error_e, framing_error_e} !== e_exp) begin
            failures++;
            $display("FAIL even_frame got data=%h pe=%b fe=%b want data=%h pe=%b fe=%b",
                     data_e, parity_error_e, framing_error_e, e_exp.d, e_exp.pe, e_exp.fe);
          end
        end
      end
    end
  end

  task automatic drive_bit(input bit sel, input logic v);
    if (sel) rx_e = v; else rx = v;
    repeat (16) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    rx_e = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input logic par_bit, input logic stop_val);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (sel) drive_bit(sel, par_bit);
    drive_bit(sel, stop_val);
    if (sel) rx_e = 1'b1; else rx = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx = 1'b1; rx_e = 1'b1; ready = 1'b1; ready_e = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if ({data, valid, parity_error, framing_error, overrun, busy} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got data=%h v=%b pe=%b fe=%b ovr=%b busy=%b want all 0",
               data, valid, parity_error, framing_error, overrun, busy);
    end
    checks++;
    if ({data_e, valid_e, busy_e} !== 10'd0) begin
      failures++;
      $display("FAIL reset_even got data=%h v=%b busy=%b want 0", data_e, valid_e, busy_e);
    end
    idle(20);
  endtask

  task automatic test_basic();
    int v0, b0;
    v0 = valid_cycles; b0 = busy_rise;
    ready = 1'b1;
    q_main.push_back(exp_t'{8'hA5, 1'b0, 1'b0});
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    idle(20);
    checks++;
    if (valid_cycles - v0 !== 1) begin
      failures++;
      $display("FAIL basic_valid_cycles got %0d want 1", valid_cycles - v0);
    end
    checks++;
    if (busy_rise - b0 !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy got rises=%0d busy=%b want 1 and 0", busy_rise - b0, busy);
    end
    checks++;
    if (q_main.size() !== 0) begin
      failures++;
      $display("FAIL basic_pending got %0d want 0", q_main.size());
    end
  endtask

  task automatic test_parity();
    q_e.push_back(exp_t'{8'h03, 1'b1, 1'b0});
    send_frame(1, 8'h03, 1'b1, 1'b1);
    idle(20);
    q_e.push_back(exp_t'{8'h03, 1'b0, 1'b0});
    send_frame(1, 8'h03, 1'b0, 1'b1);
    idle(20);
    q_e.push_back(exp_t'{8'h80, 1'b0, 1'b0});
    send_frame(1, 8'h80, 1'b1, 1'b1);
    idle(20);
    checks++;
    if (q_e.size() !== 0 || valid_e !== 1'b0 || busy_e !== 1'b0 || ovr_e_cnt !== 0) begin
      failures++;
      $display("FAIL parity_drain got pending=%0d valid=%b busy=%b ovr=%0d want 0 0 0 0",
               q_e.size(), valid_e, busy_e, ovr_e_cnt);
    end
  endtask

  task automatic test_framing();
    q_main.push_back(exp_t'{8'h55, 1'b0, 1'b1});
    send_frame(0, 8'h55, 1'b0, 1'b0);
    idle(20);
    q_main.push_back(exp_t'{8'h00, 1'b0, 1'b1});
    rx = 1'b0;
    repeat (192) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL break_busy_low_line got %b want 0", busy);
    end
    idle(40);
    checks++;
    if (q_main.size() !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL framing_drain got pending=%0d busy=%b want 0 0", q_main.size(), busy);
    end
  endtask

  task automatic test_back_to_back();
    int o0;
    o0 = ovr_cnt;
    ready = 1'b0;
    q_main.push_back(exp_t'{8'h11, 1'b0, 1'b0});
    send_frame(0, 8'h11, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    idle(20);
    checks++;
    if (ovr_cnt - o0 !== 1) begin
      failures++;
      $display("FAIL b2b_overrun_pulses got %0d want 1", ovr_cnt - o0);
    end
    checks++;
    if (valid !== 1'b1 || data !== 8'h11) begin
      failures++;
      $display("FAIL b2b_held got valid=%b data=%h want 1 11", valid, data);
    end
    ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (valid !== 1'b0 || q_main.size() !== 0) begin
      failures++;
      $display("FAIL b2b_accept got valid=%b pending=%0d want 0 0", valid, q_main.size());
    end
    q_main.push_back(exp_t'{8'h33, 1'b0, 1'b0});
    q_main.push_back(exp_t'{8'hC4, 1'b0, 1'b0});
    send_frame(0, 8'h33, 1'b0, 1'b1);
    send_frame(0, 8'hC4, 1'b0, 1'b1);
    idle(20);
    checks++;
    if (q_main.size() !== 0 || ovr_cnt - o0 !== 1) begin
      failures++;
      $display("FAIL b2b_ready_pair got pending=%0d ovr=%0d want 0 1", q_main.size(), ovr_cnt - o0);
    end
  endtask

  task automatic test_glitch();
    int v0;
    v0 = valid_cycles;
    rx = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    rx = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_detect_busy got %b want 1", busy);
    end
    idle(40);
    checks++;
    if (busy !== 1'b0 || valid_cycles !== v0) begin
      failures++;
      $display("FAIL glitch_false_start got busy=%b valid_cycles=%0d want 0 %0d", busy, valid_cycles, v0);
    end
    q_main.push_back(exp_t'{8'h0F, 1'b0, 1'b0});
    drive_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        rx = 1'b1;
        repeat (9) @(posedge clock);
        #1;
        rx = 1'b0;
        @(posedge clock);
        #1;
        rx = 1'b1;
        repeat (6) @(posedge clock);
        #1;
      end else begin
        drive_bit(0, (i < 4) ? 1'b1 : 1'b0);
      end
    end
    drive_bit(0, 1'b1);
    idle(20);
    checks++;
    if (q_main.size() !== 0) begin
      failures++;
      $display("FAIL glitch_frame_pending got %0d want 0", q_main.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h3C;
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
    rx = d[4];
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_busy_before got %b want 1", busy);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_abort got busy=%b valid=%b want 0 0", busy, valid);
    end
    idle(200);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet got busy=%b valid=%b want 0 0", busy, valid);
    end
    q_main.push_back(exp_t'{8'h3C, 1'b0, 1'b0});
    send_frame(0, 8'h3C, 1'b0, 1'b1);
    idle(20);
    checks++;
    if (q_main.size() !== 0) begin
      failures++;
      $display("FAIL midreset_next_frame_pending got %0d want 0", q_main.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_framing();
    test_back_to_back();
    test_glitch();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
